// File: rtl/fb_write_scheduler.sv
// Owns the index-memory write port: round-robin arbitration among drawing requesters plus a vsync-aligned full-frame clear.
// Build option: define WRITE_IN_BLANK_EN to confine grants and clear writes to blanking intervals.
module fb_write_scheduler #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 3,
  parameter int FB_DEPTH = 307200,
  parameter int BG_INDEX = 0
) (
  input  logic                      iVGA_CLK,
  input  logic                      iRST_n,
  input  logic                      cVS,
  input  logic                      cBLANK_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic [ADDR_W-1:0]         mem_waddr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_wenable,
  output logic [15:0]               frame_count
);

  // state       | meaning
  // ST_ARB      | serve requesters, accept clear_start
  // ST_CLR_WAIT | clear pending, still serving requesters until the next frame start
  // ST_CLEAR    | sweeping BG_INDEX over 0..FB_DEPTH-1, requesters stalled
  localparam logic [1:0] ST_ARB      = 2'd0;
  localparam logic [1:0] ST_CLR_WAIT = 2'd1;
  localparam logic [1:0] ST_CLEAR    = 2'd2;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_REQ - 1);

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              busy_q, busy_d;
  logic              last_q, last_d;
  logic              done_q;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic [15:0]       fc_q, fc_d;
  logic              vs_q;

  logic              frame_start;
  logic              wr_allow;
  logic              serve_ok;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  idx_p;
  int                idx;
  logic              handshake;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign frame_start = vs_q & ~cVS;

`ifdef WRITE_IN_BLANK_EN
  assign wr_allow = ~cBLANK_n;
`else
  logic unused_blank;
  assign unused_blank = cBLANK_n;
  assign wr_allow     = 1'b1;
`endif

  // The clear takes the port on the frame_start cycle, so no grant is issued then.
  assign serve_ok = iRST_n & wr_allow &
                    ((state_q == ST_ARB) | ((state_q == ST_CLR_WAIT) & ~frame_start));

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_p     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(rr_ptr_q) + k) % NUM_REQ;
      idx_p = PTR_W'(idx);
      if (!grant_any && req_valid[idx_p]) begin
        grant_any = 1'b1;
        grant_idx = idx_p;
      end
    end
  end

  assign handshake = serve_ok & grant_any;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    last_d     = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wen_d      = 1'b0;
    fc_d       = frame_start ? fc_q + 16'd1 : fc_q;

    case (state_q)
      ST_ARB: begin
        if (clear_start) begin
          state_d = ST_CLR_WAIT;
          busy_d  = 1'b1;
        end
      end
      ST_CLR_WAIT: begin
        if (frame_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (wr_allow) begin
          wen_d   = 1'b1;
          waddr_d = clr_addr_q;
          wdata_d = DATA_W'(BG_INDEX);
          if (clr_addr_q == CLR_LAST) begin
            state_d    = ST_ARB;
            clr_addr_d = '0;
            busy_d     = 1'b0;
            last_d     = 1'b1;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (handshake) begin
      wen_d    = 1'b1;
      waddr_d  = sel_addr;
      wdata_d  = sel_data;
      rr_ptr_d = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= '0;
      clr_addr_q <= '0;
      busy_q     <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      fc_q       <= '0;
      vs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      done_q     <= last_q;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      fc_q       <= fc_d;
      vs_q       <= cVS;
    end
  end

  assign mem_waddr   = waddr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wenable = wen_q;
  assign clear_busy  = busy_q;
  assign clear_done  = done_q;
  assign frame_count = fc_q;

endmodule
